// File: rtl/logic_gate_sched.sv
// Round-robin scheduler sharing one registered bitwise logic unit among four requesters.
// Optional completed-transfer counter enabled by defining GATE_SCHED_STATS_EN.
module logic_gate_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_y,
  output logic [1:0]         res_id,
  input  logic               res_ready,
  output logic [15:0]        ops_done
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q;
  logic [3:0]       grant;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic             found;
  logic             accept;
  logic             xfer;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] y_p1;
  logic [1:0]       id_p1;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  gate_fn = a & b;
      3'b001:  gate_fn = a | b;
      3'b010:  gate_fn = a ^ b;
      3'b011:  gate_fn = ~(a ^ b);
      3'b100:  gate_fn = ~(a & b);
      3'b101:  gate_fn = ~(a | b);
      3'b110:  gate_fn = ~a;
      default: gate_fn = a;
    endcase
  endfunction

  // First valid requester scanning from ptr upward, modulo 4
  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign accept    = (state_q == IDLE) || res_ready;
  assign req_ready = (accept && !rst) ? grant : 4'b0000;
  assign xfer      = |req_ready;

  // Stage p0: operand mux for the granted requester
  assign op_p0 = req_op[3*gidx +: 3];
  assign a_p0  = req_a[WIDTH*gidx +: WIDTH];
  assign b_p0  = req_b[WIDTH*gidx +: WIDTH];

  always_comb begin
    state_d = state_q;
    if (xfer)
      state_d = RESP;
    else if (state_q == RESP && res_ready)
      state_d = IDLE;
  end

  // Stage p1: registered result held until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      y_p1    <= '0;
      id_p1   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        ptr_q <= gidx + 2'd1;
        y_p1  <= gate_fn(op_p0, a_p0, b_p0);
        id_p1 <= gidx;
      end
    end
  end

  assign vld_p1    = (state_q == RESP);
  assign res_valid = vld_p1;
  assign res_y     = y_p1;
  assign res_id    = id_p1;

`ifdef GATE_SCHED_STATS_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk) begin
    if (rst)
      ops_q <= 16'h0000;
    else if (vld_p1 && res_ready)
      ops_q <= ops_q + 16'd1;
  end

  assign ops_done = ops_q;
`else
  assign ops_done = 16'h0000;
`endif

endmodule

// File: tb/tb_logic_gate_sched.sv
// Self-checking bench for logic_gate_sched: directed literal checks plus a randomized
// run compared every cycle against a behavioural scheduler model.
module tb_logic_gate_sched;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [11:0]    req_op;
  logic [4*W-1:0] req_a, req_b;
  logic [3:0]     req_ready;
  logic           res_valid;
  logic [W-1:0]   res_y;
  logic [1:0]     res_id;
  logic           res_ready;
  logic [15:0]    ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic           m_valid = 1'b0;
  logic [W-1:0]   m_y     = '0;
  logic [1:0]     m_id    = '0;
  int             m_ptr   = 0;
  logic [15:0]    m_ops   = '0;

  logic_gate_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_y(res_y), .res_id(res_id),
    .res_ready(res_ready), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gate(input int op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    if (op == 0) r = a & b;
    else if (op == 1) r = a | b;
    else if (op == 2) r = a ^ b;
    else if (op == 3) r = ~(a ^ b);
    else if (op == 4) r = ~(a & b);
    else if (op == 5) r = ~(a | b);
    else if (op == 6) r = ~a;
    else r = a;
    return r;
  endfunction

  function automatic logic [15:0] exp_ops(input logic [15:0] v);
`ifdef GATE_SCHED_STATS_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  // Behavioural model: compare on the falling edge, then advance to the next rising edge
  always @(negedge clk) begin
    logic [3:0] e_rdy;
    int g;
    e_rdy = 4'b0000;
    g = -1;
    if (!rst && (!m_valid || res_ready)) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (g >= 0) e_rdy = 4'(1 << g);
    end
    chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
    chk("m_res_valid", 32'(res_valid), 32'(m_valid));
    chk("m_ops_done",  32'(ops_done),  32'(exp_ops(m_ops)));
    if (m_valid) begin
      chk("m_res_y",  32'(res_y),  32'(m_y));
      chk("m_res_id", 32'(res_id), 32'(m_id));
    end
    if (rst) begin
      m_valid = 1'b0; m_y = '0; m_id = '0; m_ptr = 0; m_ops = '0;
    end else begin
      if (m_valid && res_ready) m_ops = m_ops + 16'd1;
      if (g >= 0) begin
        m_y     = ref_gate(int'(req_op[3*g +: 3]), req_a[W*g +: W], req_b[W*g +: W]);
        m_id    = 2'(g);
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 4;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    tick();
    repeat (2) begin
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_res_y",     32'(res_y),     32'h0);
      chk("rst_ops_done",  32'(ops_done),  32'h0);
      tick();
    end

    // XNOR from requester 0, first grant after reset
    rst = 1'b0; res_ready = 1'b1;
    set_req(0, 3'b011, 8'hF0, 8'hCC);
    #1 chk("xnor_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'h0;
    #1;
    chk("xnor_valid", 32'(res_valid), 32'h1);
    chk("xnor_y",     32'(res_y),     32'hC3);
    chk("xnor_id",    32'(res_id),    32'h0);
    tick();

    // BUF 3C from requester 1, then reset while holding it
    set_req(1, 3'b111, 8'h3C, 8'h00);
    req_valid = 4'b0010; res_ready = 1'b0;
    #1 chk("buf_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    #1;
    chk("buf_y",     32'(res_y),     32'h3C);
    chk("buf_valid", 32'(res_valid), 32'h1);
    rst = 1'b1; res_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 3'b000, 8'hFF, 8'(8'h0F + i));
    req_valid = 4'hF;
    #1;
    chk("midrst_valid", 32'(res_valid), 32'h0);
    chk("midrst_y",     32'(res_y),     32'h0);
    chk("midrst_ops",   32'(ops_done),  32'h0);

    // Round robin with all requesters valid
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_id", 32'(res_id), 32'((k - 1) % 4));
        chk("rr_y",  32'(res_y),  32'(8'h0F + (k - 1) % 4));
      end
      tick();
      #1;
    end

    // NOR from requester 2 held under backpressure
    set_req(2, 3'b101, 8'h0A, 8'h50);
    req_valid = 4'b0100;
    chk("nor_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'hF; res_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_y",     32'(res_y),     32'hA5);
      chk("bp_ready", 32'(req_ready), 32'h0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'h8);
    chk("bp_release_y",     32'(res_y),     32'hA5);
    tick();
    req_valid = 4'h0;
    tick();

    // Five completed transfers after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0001; res_ready = 1'b1;
    repeat (5) tick();
    req_valid = 4'h0;
    tick();
    #1;
`ifdef GATE_SCHED_STATS_EN
    chk("stats_ops", 32'(ops_done), 32'd5);
`else
    chk("stats_ops", 32'(ops_done), 32'd0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      req_valid = 4'($urandom);
      req_op    = 12'($urandom);
      req_a     = 32'($urandom);
      req_b     = 32'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 4'h0; res_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
